branch_resolve_ctrl: RTL and testbench
======================================

# branch_resolve_ctrl

In-order tracker that sits between IF, the 2-bit BHT branch predictor and ROB commit. Records every conditional-branch prediction made at fetch and matches it against the committed outcome. Sequences the predictor's single BHT update port and raises a one-cycle flush with a redirect PC on a misprediction. JAL and JALR are never recorded.

## Interface
- `DEPTH`, 16: tracked in-flight branches; power of two, 2..256.
- `ADDR_W`, 32: PC width.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rdy` in 1: global enable. When low, all state holds and inputs are ignored.
- `push_valid` in 1: IF has issued a conditional branch (OPCODE_BR) this cycle.
- `push_pc` in ADDR_W: PC of that branch.
- `push_pred_taken` in 1: predictor decision, the BHT counter's MSB.
- `full` out 1: no push can be accepted. IF stalls branch issue while this is high.
- `commit_valid` in 1: ROB commits the oldest conditional branch this cycle.
- `commit_taken` in 1: resolved direction.
- `commit_target` in ADDR_W: resolved taken target.
- `clear` in 1: external flush, from a JALR redirect or another non-branch flush. Empties the queue.
- `upd_valid` out 1: BHT update strobe.
- `upd_pc` out ADDR_W: PC used for the BHT index.
- `upd_taken` out 1: outcome to train with.
- `mispredict` out 1: one-cycle flush request.
- `redirect_pc` out ADDR_W: correct next PC while `mispredict` is high.

## Operation
- Storage is a circular FIFO of {pc, pred_taken}, `DEPTH` entries, with head/tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Pointers wrap modulo `DEPTH`.
- FSM states: RUN and FLUSH.
  - RUN: accepts pushes and commits.
  - FLUSH: lasts exactly one cycle. The queue is empty, pushes are dropped, and `full`=1. The next state is always RUN.
- Push in RUN: if `push_valid` && !`full`, write at tail and advance tail.
- Commit in RUN with count>0: pop head, then register the following.
  - `upd_valid`=1, `upd_pc`=head.pc, `upd_taken`=`commit_taken`.
  - If head.pred_taken != `commit_taken`:
    - `mispredict`=1.
    - `redirect_pc` = `commit_taken` ? `commit_target` : head.pc+4. The +4 wraps modulo 2^ADDR_W.
    - Reset head, tail and count to 0, discard any same-cycle push, and enter FLUSH.
- Commit with count==0 is a protocol error. It is ignored: no update and no mispredict.
- `clear` in either state empties the queue and enters FLUSH. It does not assert `mispredict`.
  - If a commit arrives in the same cycle as `clear`, the commit's BHT update is still issued.
  - `mispredict` is suppressed in that cycle; `clear` has priority on redirect.
- `full` = (count==DEPTH) || state==FLUSH. It is computed from current-cycle state only.
  - A push in the same cycle as a commit at count==DEPTH is refused.
  - A commit and push at count==0 accepts the push and ignores the commit.
- Reset values: `full`=0, `upd_valid`=0, `upd_pc`=0, `upd_taken`=0, `mispredict`=0, `redirect_pc`=0. State is RUN, pointers and count are 0.
- A reset assertion mid-operation takes effect immediately, without waiting for `clk`, and drops all entries.

## Timing
- `upd_*`, `mispredict` and `redirect_pc` are registered. They are valid in the cycle after the commit edge and are high for exactly one cycle.
- BHT sees the update at the edge after that, for a total of 2 edges from commit to trained counter.
- Push to commit-eligible: 1 edge. An entry pushed at edge N can be committed from edge N+1 onward.
- After a mispredict edge: `full`=1 for one cycle (FLUSH), and pushes are accepted again from the following edge.
- With `rdy` low: no pointer moves, and strobe outputs are forced to 0 at the next edge.

## Configuration
- `BR_STATS_EN` defined: two 32-bit counters, `stat_commits` and `stat_mispredicts`, are added as extra outputs.
  - `stat_commits` increments on each accepted commit; `stat_mispredicts` on each asserted `mispredict`.
  - Both wrap at 2^32 and reset to 0.
- `BR_STATS_EN` undefined: the counters and ports are absent, with no other behavioural change.

## Test plan
- Reset, then push 3 branches (pc 0x100/0x104/0x108, pred 0/0/0), then commit not-taken ×3. Expect 3 `upd_valid` pulses with `upd_pc` 0x100, 0x104, 0x108, `upd_taken`=0, `mispredict` never high.
- Push pc 0x200 with pred=0, then commit taken with target 0x180. Expect `mispredict`=1 and `redirect_pc`=0x180 for one cycle, then `full`=1 for one cycle, then `full`=0 with the queue empty.
- Push pc 0xFFFFFFFC with pred=1, then commit not-taken. Expect `redirect_pc`=0x00000000 (wrap).
- Push 16 entries: `full`=1 at count 16. Then issue a push and a commit together. Expect the push refused and count 15. Push again and expect it accepted; pointers wrap past index 15.
- Push 2 entries, then assert `clear` in the same cycle as a correctly predicted commit. Expect `upd_valid`=1, `mispredict`=0, queue empty, and a later commit ignored.
- Drop `rst` while 5 entries are queued, between clock edges. Expect the outputs to return to their reset values immediately; after release, a commit produces no update.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// In-order conditional-branch tracker: matches fetch-time predictions against committed
// outcomes, drives the BHT update port and requests a flush on mispredict. Optional: BR_STATS_EN.
module branch_resolve_ctrl #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              push_valid,
   input  logic [ADDR_W-1:0] push_pc,
   input  logic              push_pred_taken,
   output logic              full,
   input  logic              commit_valid,
   input  logic              commit_taken,
   input  logic [ADDR_W-1:0] commit_target,
   input  logic              clear,
   output logic              upd_valid,
   output logic [ADDR_W-1:0] upd_pc,
   output logic              upd_taken,
   output logic              mispredict,
   output logic [ADDR_W-1:0] redirect_pc
`ifdef BR_STATS_EN
   ,
   output logic [31:0]       stat_commits,
   output logic [31:0]       stat_mispredicts
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t             state;
   logic [ADDR_W-1:0]  pc_mem [DEPTH];
   logic [DEPTH-1:0]   pred_mem;
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [CNT_W-1:0]   count;

   logic              push_ok;
   logic              commit_ok;
   logic              wrong;
   logic              wr_en;
   logic [ADDR_W-1:0] head_pc;
   logic              head_pred;

   assign full      = (count == CNT_W'(DEPTH)) || (state == FLUSH);
   assign head_pc   = pc_mem[head];
   assign head_pred = pred_mem[head];
   assign push_ok   = push_valid && !full;
   assign commit_ok = commit_valid && (count != '0) && (state == RUN);
   assign wrong     = commit_ok && (head_pred != commit_taken);
   assign wr_en     = rdy && push_ok && !wrong && !clear;

   // Entry payload carries no reset; validity is tracked by head/tail/count alone.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         pc_mem[tail]   <= push_pc;
         pred_mem[tail] <= push_pred_taken;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= RUN;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         upd_valid   <= 1'b0;
         upd_pc      <= '0;
         upd_taken   <= 1'b0;
         mispredict  <= 1'b0;
         redirect_pc <= '0;
      end else if (!rdy) begin
         upd_valid  <= 1'b0;
         mispredict <= 1'b0;
      end else begin
         upd_valid  <= commit_ok;
         mispredict <= wrong && !clear;
         if (commit_ok) begin
            upd_pc    <= head_pc;
            upd_taken <= commit_taken;
         end
         // An external clear owns the redirect, so our own flush request is withheld.
         if (wrong && !clear) begin
            redirect_pc <= commit_taken ? commit_target : head_pc + ADDR_W'(4);
         end
         if (clear || wrong) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= FLUSH;
         end else begin
            state <= RUN;
            if (push_ok)   tail <= tail + PTR_W'(1);
            if (commit_ok) head <= head + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(commit_ok);
         end
      end
   end

`ifdef BR_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_commits     <= '0;
         stat_mispredicts <= '0;
      end else if (rdy) begin
         if (commit_ok)       stat_commits     <= stat_commits + 32'd1;
         if (wrong && !clear) stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: a queue model predicts each cycle's update/flush result.
module tb_branch_resolve_ctrl;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        push_valid;
   logic [31:0] push_pc;
   logic        push_pred_taken;
   logic        full;
   logic        commit_valid;
   logic        commit_taken;
   logic [31:0] commit_target;
   logic        clear;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic        mispredict;
   logic [31:0] redirect_pc;

   typedef struct {
      logic [31:0] pc;
      logic        pred;
   } ent_t;

   ent_t        mq[$];
   bit          mflush;
   logic [66:0] sb[$];
   logic [66:0] ob[$];
   int          n_compared;
   int          n_mismatched;

   branch_resolve_ctrl #(.DEPTH(16), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .push_valid(push_valid), .push_pc(push_pc), .push_pred_taken(push_pred_taken),
      .full(full),
      .commit_valid(commit_valid), .commit_taken(commit_taken), .commit_target(commit_target),
      .clear(clear),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .mispredict(mispredict), .redirect_pc(redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock of stimulus: model predicts the registered result, then the DUT result is captured.
   task automatic cycle(input logic pv, input logic [31:0] ppc, input logic ppred,
                        input logic cv, input logic ct, input logic [31:0] ctgt,
                        input logic clr, input logic rdy_i);
      ent_t        h;
      ent_t        n;
      bit          mfull;
      bit          push_ok;
      bit          mis;
      logic        e_valid;
      logic        e_mis;
      logic [31:0] e_pc;
      logic        e_taken;
      logic [31:0] e_redir;
      e_valid = 0; e_mis = 0; e_pc = 0; e_taken = 0; e_redir = 0; mis = 0;
      if (rdy_i) begin
         mfull   = (mq.size() == 16) || mflush;
         push_ok = pv && !mfull;
         if (cv && mq.size() > 0 && !mflush) begin
            h       = mq.pop_front();
            mis     = (h.pred != ct);
            e_valid = 1;
            e_pc    = h.pc;
            e_taken = ct;
            e_mis   = mis && !clr;
            if (e_mis) e_redir = ct ? ctgt : h.pc + 32'd4;
         end
         if (clr || mis) begin
            mq.delete();
            mflush = 1;
         end else begin
            mflush = 0;
            if (push_ok) begin
               n.pc = ppc; n.pred = ppred;
               mq.push_back(n);
            end
         end
      end
      sb.push_back({e_valid, e_mis, e_pc, e_taken, e_redir});
      push_valid = pv; push_pc = ppc; push_pred_taken = ppred;
      commit_valid = cv; commit_taken = ct; commit_target = ctgt;
      clear = clr; rdy = rdy_i;
      @(posedge clk);
      @(negedge clk);
      ob.push_back({upd_valid, mispredict,
                    upd_valid ? upd_pc : 32'd0, upd_valid ? upd_taken : 1'b0,
                    mispredict ? redirect_pc : 32'd0});
      push_valid = 0; commit_valid = 0; clear = 0; rdy = 1;
   endtask

   task automatic test_reset();
      n_compared++; if (full !== 1'b0)       begin n_mismatched++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
      n_compared++; if (upd_valid !== 1'b0)  begin n_mismatched++; $display("[TB] FAIL reset_upd_valid: got %b expected 0", upd_valid); end
      n_compared++; if (upd_pc !== 32'd0)    begin n_mismatched++; $display("[TB] FAIL reset_upd_pc: got %h expected 0", upd_pc); end
      n_compared++; if (upd_taken !== 1'b0)  begin n_mismatched++; $display("[TB] FAIL reset_upd_taken: got %b expected 0", upd_taken); end
      n_compared++; if (mispredict !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_mispredict: got %b expected 0", mispredict); end
      n_compared++; if (redirect_pc !== 32'd0) begin n_mismatched++; $display("[TB] FAIL reset_redirect_pc: got %h expected 0", redirect_pc); end
   endtask

   task automatic test_correct_predict();
      logic [66:0] e;
      logic [66:0] o;
      for (int i = 0; i < 3; i++) cycle(1, 32'h100 + 32'(4 * i), 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 32'h999, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 1);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = ob.pop_front(); n_compared++;
         if (o !== e) begin n_mismatched++; $display("[TB] FAIL correct_predict_update: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_mispredict();
      logic [66:0] e;
      logic [66:0] o;
      cycle(1, 32'h200, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 1, 1, 32'h180, 0, 1);
      n_compared++; if (full !== 1'b1) begin n_mismatched++; $display("[TB] FAIL flush_full: got %b expected 1", full); end
      cycle(1, 32'h300, 0, 0, 0, 0, 0, 1);
      n_compared++; if (full !== 1'b0) begin n_mismatched++; $display("[TB] FAIL after_flush_full: got %b expected 0", full); end
      cycle(0, 0, 0, 1, 1, 32'h444, 0, 1);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = ob.pop_front(); n_compared++;
         if (o !== e) begin n_mismatched++; $display("[TB] FAIL mispredict_update: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_redirect_wrap();
      logic [66:0] e;
      logic [66:0] o;
      cycle(1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 1, 0, 32'h1234, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 1);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = ob.pop_front(); n_compared++;
         if (o !== e) begin n_mismatched++; $display("[TB] FAIL redirect_wrap: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_full();
      logic [66:0] e;
      logic [66:0] o;
      for (int i = 0; i < 16; i++) cycle(1, 32'h1000 + 32'(4 * i), 1'(i), 0, 0, 0, 0, 1);
      n_compared++; if (full !== 1'b1) begin n_mismatched++; $display("[TB] FAIL full_at_16: got %b expected 1", full); end
      cycle(1, 32'h2000, 0, 1, mq[0].pred, 0, 0, 1);
      n_compared++; if (full !== 1'b0) begin n_mismatched++; $display("[TB] FAIL full_at_15: got %b expected 0", full); end
      cycle(1, 32'h2004, 1, 0, 0, 0, 0, 1);
      n_compared++; if (full !== 1'b1) begin n_mismatched++; $display("[TB] FAIL full_refill: got %b expected 1", full); end
      for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1, mq[0].pred, 32'h77, 0, 1);
      cycle(0, 0, 0, 1, 0, 0, 0, 1);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = ob.pop_front(); n_compared++;
         if (o !== e) begin n_mismatched++; $display("[TB] FAIL full_drain: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_clear();
      logic [66:0] e;
      logic [66:0] o;
      cycle(1, 32'h400, 1, 0, 0, 0, 0, 1);
      cycle(1, 32'h404, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 1, 1, 32'h800, 1, 1);
      n_compared++; if (full !== 1'b1) begin n_mismatched++; $display("[TB] FAIL clear_full: got %b expected 1", full); end
      cycle(0, 0, 0, 1, 0, 0, 0, 1);
      cycle(0, 0, 0, 1, 0, 0, 0, 1);
      cycle(1, 32'h500, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 1, 1, 32'h900, 1, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 1);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = ob.pop_front(); n_compared++;
         if (o !== e) begin n_mismatched++; $display("[TB] FAIL clear_commit: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_rdy();
      logic [66:0] e;
      logic [66:0] o;
      cycle(1, 32'h600, 1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 1, 0, 0, 1);
      cycle(1, 32'h604, 1, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 1, 1, 0, 0, 0);
      cycle(0, 0, 0, 1, 1, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 1);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = ob.pop_front(); n_compared++;
         if (o !== e) begin n_mismatched++; $display("[TB] FAIL rdy_hold: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_async_reset();
      logic [66:0] e;
      logic [66:0] o;
      for (int i = 0; i < 6; i++) cycle(1, 32'h700 + 32'(4 * i), 1, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 1, 1, 0, 0, 1);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = ob.pop_front(); n_compared++;
         if (o !== e) begin n_mismatched++; $display("[TB] FAIL pre_reset_update: got %h expected %h", o, e); end
      end
      #2 rst = 1'b0;
      #1;
      n_compared++; if (upd_valid !== 1'b0)  begin n_mismatched++; $display("[TB] FAIL async_upd_valid: got %b expected 0", upd_valid); end
      n_compared++; if (upd_pc !== 32'd0)    begin n_mismatched++; $display("[TB] FAIL async_upd_pc: got %h expected 0", upd_pc); end
      n_compared++; if (upd_taken !== 1'b0)  begin n_mismatched++; $display("[TB] FAIL async_upd_taken: got %b expected 0", upd_taken); end
      n_compared++; if (mispredict !== 1'b0) begin n_mismatched++; $display("[TB] FAIL async_mispredict: got %b expected 0", mispredict); end
      n_compared++; if (redirect_pc !== 32'd0) begin n_mismatched++; $display("[TB] FAIL async_redirect_pc: got %h expected 0", redirect_pc); end
      n_compared++; if (full !== 1'b0)       begin n_mismatched++; $display("[TB] FAIL async_full: got %b expected 0", full); end
      mq.delete();
      mflush = 0;
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      cycle(0, 0, 0, 1, 1, 0, 0, 1);
      cycle(0, 0, 0, 1, 0, 0, 0, 1);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = ob.pop_front(); n_compared++;
         if (o !== e) begin n_mismatched++; $display("[TB] FAIL post_reset_commit: got %h expected %h", o, e); end
      end
   endtask

   initial begin
      n_compared = 0; n_mismatched = 0; mflush = 0;
      rst = 1'b0; rdy = 1'b1; clear = 1'b0;
      push_valid = 1'b0; push_pc = '0; push_pred_taken = 1'b0;
      commit_valid = 1'b0; commit_taken = 1'b0; commit_target = '0;
      #12 rst = 1'b1;
      @(negedge clk);
      $display("[TB] starting branch_resolve_ctrl checks");
      test_reset();
      test_correct_predict();
      test_mispredict();
      test_redirect_wrap();
      test_full();
      test_clear();
      test_rdy();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
